// File: rtl/sdp_ram_read_checker.sv
// Read-side sequencer for a simple dual-port RAM: one linear pass over DEPTH words,
// checked against the k+1 write pattern. Define SDP_READ_CHECK_EN to build the comparator.
module sdp_ram_read_checker #(
   parameter int DEPTH  = 100,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              wr_done,
   output logic              enb,
   output logic [ADDR_W-1:0] addrb,
   input  logic [DATA_W-1:0] doutb,
   output logic              dout_valid,
   output logic [DATA_W-1:0] dout_data,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [7:0]        err_cnt,
   output logic [ADDR_W-1:0] first_err_addr
);

   // state  | meaning
   // IDLE   | waiting for start
   // WAIT_W | pass requested, waiting for the write side to report completion
   // READ   | issuing DEPTH consecutive reads
   // DRAIN  | reads issued, waiting for the read pipeline to empty
   // DONE   | one-cycle completion pulse, pass result latched
   typedef enum logic [2:0] {IDLE, WAIT_W, READ, DRAIN, DONE} state_t;

   localparam logic [RD_LAT-1:0] LAST_ONLY = RD_LAT'(1) << (RD_LAT - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                wr_seen_q, wr_seen_d;
   logic [RD_LAT-1:0]   vld_q, vld_d;
   logic                pass_q, pass_d;
   logic                clr_stats;

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      clr_stats = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = WAIT_W;
               clr_stats = 1'b1;
            end
         end
         WAIT_W: begin
            if (wr_seen_q) state_d = READ;
         end
         READ: begin
            if (rd_addr_q == LAST_ADDR) begin
               state_d   = DRAIN;
               rd_addr_d = '0;
            end else begin
               rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (vld_q == LAST_ONLY) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // a completion pulse landing in DONE must survive into the next pass
   assign wr_seen_d = wr_done | (wr_seen_q & (state_q != DONE));

   assign enb        = (state_q == READ);
   assign addrb      = enb ? rd_addr_q : '0;
   assign vld_d      = (vld_q << 1) | RD_LAT'(enb);
   assign dout_valid = vld_q[RD_LAT-1];
   assign dout_data  = doutb;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign pass       = pass_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
         wr_seen_q <= 1'b0;
         vld_q     <= '0;
         pass_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         wr_seen_q <= wr_seen_d;
         vld_q     <= vld_d;
         pass_q    <= pass_d;
      end
   end

`ifdef SDP_READ_CHECK_EN
   logic [ADDR_W-1:0] apipe_q [RD_LAT];
   logic [7:0]        err_cnt_q, err_cnt_d;
   logic [ADDR_W-1:0] first_err_q, first_err_d;
   logic              mismatch;

   assign mismatch = dout_valid &&
                     (doutb != (DATA_W'(apipe_q[RD_LAT-1]) + DATA_W'(1)));

   always_comb begin
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      if (clr_stats) begin
         err_cnt_d   = '0;
         first_err_d = '0;
      end else if (mismatch) begin
         if (err_cnt_q == 8'd0)  first_err_d = apipe_q[RD_LAT-1];
         if (err_cnt_q != 8'hFF) err_cnt_d   = err_cnt_q + 8'd1;
      end
   end

   always_comb begin
      pass_d = pass_q;
      if (clr_stats)              pass_d = 1'b0;
      else if (state_q == DONE)   pass_d = (err_cnt_q == 8'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LAT; i++) apipe_q[i] <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
      end else begin
         apipe_q[0] <= addrb;
         for (int i = 1; i < RD_LAT; i++) apipe_q[i] <= apipe_q[i-1];
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
      end
   end

   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_q;
`else
   always_comb begin
      pass_d = pass_q;
      if (clr_stats)              pass_d = 1'b0;
      else if (state_q == DONE)   pass_d = 1'b1;
   end

   assign err_cnt        = '0;
   assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_sdp_ram_read_checker.sv
// Scoreboard bench for sdp_ram_read_checker: randomized passes against a RAM model
// and a pass-level reference of read timing, data and mismatch statistics.
`timescale 1ns/1ps
module tb_sdp_ram_read_checker;
   localparam int DEPTH  = 100;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 16;
   localparam int RD_LAT = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              wr_done = 1'b0;
   logic              enb;
   logic [ADDR_W-1:0] addrb;
   logic [DATA_W-1:0] doutb;
   logic              dout_valid;
   logic [DATA_W-1:0] dout_data;
   logic              busy, done, pass;
   logic [7:0]        err_cnt;
   logic [ADDR_W-1:0] first_err_addr;

   sdp_ram_read_checker #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .start(start), .wr_done(wr_done),
      .enb(enb), .addrb(addrb), .doutb(doutb),
      .dout_valid(dout_valid), .dout_data(dout_data),
      .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .first_err_addr(first_err_addr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM port B model, two-cycle read latency
   logic [DATA_W-1:0] mem [128];
   logic [DATA_W-1:0] ram_p1;
   always @(posedge clk) begin
      ram_p1 <= mem[addrb];
      doutb  <= ram_p1;
   end

   typedef struct { int cyc; logic [ADDR_W-1:0] addr; } enb_exp_t;
   typedef struct { int cyc; logic [DATA_W-1:0] data; } dat_exp_t;
   typedef struct { int cyc; logic [7:0] errs; logic [ADDR_W-1:0] first; logic ok; } res_exp_t;

   enb_exp_t enb_q[$];
   dat_exp_t dat_q[$];
   res_exp_t res_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int busy_lo = 1;
   int busy_hi = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor: pops scoreboard entries whenever the DUT presents activity
   initial begin
      enb_exp_t e;
      dat_exp_t d;
      res_exp_t r;
      bit       pass_pend;
      int       pass_cyc;
      logic     pass_exp;
      pass_pend = 0;
      pass_cyc  = 0;
      pass_exp  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            pass_pend = 0;
         end else begin
            check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            if (enb) begin
               if (enb_q.size() == 0) check("enb_unexpected", 32'(enb), 32'd0);
               else begin
                  e = enb_q.pop_front();
                  check("enb_cycle", 32'(cyc), 32'(e.cyc));
                  check("addrb", 32'(addrb), 32'(e.addr));
               end
            end else begin
               check("addrb_idle", 32'(addrb), 32'd0);
            end
            if (dout_valid) begin
               if (dat_q.size() == 0) check("valid_unexpected", 32'(dout_valid), 32'd0);
               else begin
                  d = dat_q.pop_front();
                  check("valid_cycle", 32'(cyc), 32'(d.cyc));
                  check("dout_data", 32'(dout_data), 32'(d.data));
               end
            end
            if (pass_pend && cyc == pass_cyc) begin
               check("pass", 32'(pass), 32'(pass_exp));
               pass_pend = 0;
            end
            if (done) begin
               if (res_q.size() == 0) check("done_unexpected", 32'(done), 32'd0);
               else begin
                  r = res_q.pop_front();
                  check("done_cycle", 32'(cyc), 32'(r.cyc));
                  check("err_cnt", 32'(err_cnt), 32'(r.errs));
                  check("first_err_addr", 32'(first_err_addr), 32'(r.first));
                  pass_pend = 1;
                  pass_cyc  = cyc + 1;
                  pass_exp  = r.ok;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic restore_mem();
      for (int k = 0; k < 128; k++) mem[k] = DATA_W'(k + 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_enb"}, 32'(enb), 32'd0);
      check({tag, "_addrb"}, 32'(addrb), 32'd0);
      check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
      check({tag, "_first_err"}, 32'(first_err_addr), 32'd0);
   endtask

   // wr_off < 0: wr_done pulsed -wr_off cycles before start; otherwise wr_off cycles after it
   task automatic run_pass(input int wr_off, input bit stray_start, input bit rst_mid);
      int s, w, rs, dc, errs, first;
      bit found;
      logic ok;
      if (wr_off < 0) begin
         w = cyc;
         wr_done = 1'b1;
         step();
         wr_done = 1'b0;
         repeat (-wr_off - 1) step();
      end
      s = cyc;
      if (wr_off >= 0) w = s + wr_off;
      rs = ((s > w) ? s : w) + 2;
      dc = rs + DEPTH + RD_LAT;

      errs = 0; first = 0; found = 0;
      for (int k = 0; k < DEPTH; k++) begin
         enb_q.push_back('{rs + k, ADDR_W'(k)});
         dat_q.push_back('{rs + k + RD_LAT, mem[k]});
         if (mem[k] != DATA_W'(k + 1)) begin
            if (!found) first = k;
            found = 1;
            if (errs < 255) errs++;
         end
      end
`ifdef SDP_READ_CHECK_EN
      ok = (errs == 0);
`else
      errs = 0; first = 0; ok = 1'b1;
`endif
      res_q.push_back('{dc, 8'(errs), ADDR_W'(first), ok});
      busy_lo = s + 1;
      busy_hi = dc;

      start = 1'b1;
      if (wr_off == 0) wr_done = 1'b1;
      step();
      start = 1'b0;
      wr_done = 1'b0;
      if (wr_off > 0) begin
         repeat (wr_off - 1) step();
         wr_done = 1'b1;
         step();
         wr_done = 1'b0;
      end
      if (stray_start) begin
         while (cyc < rs + 10) step();
         start = 1'b1;
         step();
         start = 1'b0;
      end
      if (rst_mid) begin
         while (cyc < rs + 60) step();
         rst = 1'b1;
         busy_hi = cyc - 1;
         enb_q.delete();
         dat_q.delete();
         res_q.delete();
         #1;
         check_reset_outputs("midrst");
         repeat (3) step();
         rst = 1'b0;
         repeat (120) step();
      end else begin
         while (cyc < dc + 3) step();
      end
      check("res_left", 32'(res_q.size()), 32'd0);
      check("enb_left", 32'(enb_q.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      restore_mem();
      #2;
      check_reset_outputs("rst");
      repeat (3) step();
      rst = 1'b0;
      repeat (3) step();

      run_pass(-3, 0, 0);
      run_pass(50, 1, 0);

      mem[37] = '0;
      run_pass(-1, 0, 0);
      restore_mem();

      mem[5] = 16'hBEEF;
      run_pass(0, 0, 0);
      restore_mem();

      for (int k = 0; k < DEPTH; k++)
         mem[k] = DATA_W'(k + 1) ^ DATA_W'($urandom_range(1, 65535));
      run_pass(-2, 0, 0);
      run_pass(int'($urandom_range(0, 10)), 0, 0);
      restore_mem();

      run_pass(-2, 0, 1);
      run_pass(20, 0, 0);

      for (int p = 0; p < 6; p++) begin
         n = int'($urandom_range(0, 4));
         for (int j = 0; j < n; j++)
            mem[$urandom_range(0, DEPTH - 1)] = DATA_W'($urandom);
         run_pass(int'($urandom_range(0, 20)) - 5, ($urandom_range(0, 1) == 1), 0);
         restore_mem();
         repeat (int'($urandom_range(0, 5))) step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
